arcade_input_cond: RTL

- Input-conditioning stage between the controller sources and the Galaga core's player inputs.
- Sources are the USB joystick, the DB9/SNAC pad and the PS/2 key flags, already OR-merged per player.
- Synchronises and debounces every raw button and applies the Horz-orientation direction remap.
- Turns coin requests into fixed-width, spaced coin pulses, so the core's credit counter never sees runt or merged pulses.

---
 rtl/arcade_input_pkg.sv | 27 ++
 rtl/in_debounce.sv | 51 +++++
 rtl/arcade_input_cond.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/arcade_input_pkg.sv
// Shared constants and types for the arcade input-conditioning stage:
// button bit positions, coin FSM states and the tick-period helper.
package arcade_input_pkg;

   localparam int BTN_RIGHT  = 0;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_UP     = 3;
   localparam int BTN_FIRE   = 4;
   localparam int BTN_START1 = 5;
   localparam int BTN_START2 = 6;
   localparam int BTN_COIN   = 7;

   typedef logic [7:0] btn_vec_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2
   } coin_st_t;

   // Number of clk_sys cycles spanned by `ms` milliseconds.
   function automatic int ms_to_ticks(input int clk_hz, input int ms);
      return (clk_hz / 1000) * ms;
   endfunction

endpackage

// File: rtl/in_debounce.sv
// Single-bit two-flop synchroniser followed by a tick-driven debouncer:
// the output follows the synced input once it has differed for DEB_MS ticks.
module in_debounce
   import arcade_input_pkg::*;
#(
   parameter int DEB_MS = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic tick_i,
   input  logic raw_i,
   output logic deb_o
);

   localparam int CW = $clog2(DEB_MS + 1);

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          deb_q, deb_d;

   always_comb begin
      cnt_d = cnt_q;
      deb_d = deb_q;
      if (sync_q[1] == deb_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         // The tick that brings the count to DEB_MS commits the new value.
         if (cnt_q == CW'(DEB_MS - 1)) begin
            deb_d = sync_q[1];
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
         cnt_q  <= '0;
         deb_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], raw_i};
         cnt_q  <= cnt_d;
         deb_q  <= deb_d;
      end
   end

   assign deb_o = deb_q;

endmodule

// File: rtl/arcade_input_cond.sv
// Player input conditioning: sync/debounce, Horz direction remap and coin
// pulse shaping. Optional autofire is enabled by ARCADE_INPUT_AUTOFIRE_EN.
module arcade_input_cond
   import arcade_input_pkg::*;
#(
   parameter int CLK_HZ  = 18432000,
   parameter int DEB_MS  = 2,
   parameter int COIN_MS = 100,
   parameter int GAP_MS  = 100
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   ,
   parameter int AF_MS   = 50
`endif
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic [7:0] raw_p1,
   input  logic [7:0] raw_p2,
   input  logic       rotate,
`ifdef ARCADE_INPUT_AUTOFIRE_EN
   input  logic       autofire,
`endif
   output logic       left1,
   output logic       right1,
   output logic       fire1,
   output logic       start1,
   output logic       left2,
   output logic       right2,
   output logic       fire2,
   output logic       start2,
   output logic       coin,
   output logic       coin_busy
);

   localparam int TICK_DIV = ms_to_ticks(CLK_HZ, 1);
   localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CMAX     = (COIN_MS > GAP_MS) ? COIN_MS : GAP_MS;
   localparam int CW       = $clog2(CMAX + 1);

   logic [PW-1:0] pre_q;
   logic          tick;

   assign tick = (pre_q == PW'(TICK_DIV - 1));

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n)  pre_q <= '0;
      else if (tick) pre_q <= '0;
      else           pre_q <= pre_q + 1'b1;
   end

   logic [15:0] raw_all, deb_all;
   btn_vec_t    deb_p1, deb_p2;

   assign raw_all = {raw_p2, raw_p1};

   generate
      for (genvar i = 0; i < 16; i++) begin : g_deb
         in_debounce #(.DEB_MS(DEB_MS)) u_deb (
            .clk_i  (clk_sys),
            .rst_ni (reset_n),
            .tick_i (tick),
            .raw_i  (raw_all[i]),
            .deb_o  (deb_all[i])
         );
      end
   endgenerate

   assign deb_p1 = deb_all[7:0];
   assign deb_p2 = deb_all[15:8];

   // rotate is quasi-static, so a plain synchroniser is enough.
   logic [1:0] rot_q;
   logic       rot;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) rot_q <= '0;
      else          rot_q <= {rot_q[0], rotate};
   end

   assign rot = rot_q[1];

   logic [1:0] deb_fire, fire_nxt;
   assign deb_fire = {deb_p2[BTN_FIRE], deb_p1[BTN_FIRE]};

`ifdef ARCADE_INPUT_AUTOFIRE_EN
   localparam int AW = $clog2(AF_MS + 1);

   logic [1:0][AW-1:0] af_cnt_q;
   logic [1:0]         af_ph_q;

   // Phase parks high while released so a fresh press starts with fire on.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         af_cnt_q <= '0;
         af_ph_q  <= '1;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!deb_fire[i] || !autofire) begin
               af_cnt_q[i] <= '0;
               af_ph_q[i]  <= 1'b1;
            end else if (tick) begin
               if (af_cnt_q[i] == AW'(AF_MS - 1)) begin
                  af_cnt_q[i] <= '0;
                  af_ph_q[i]  <= ~af_ph_q[i];
               end else begin
                  af_cnt_q[i] <= af_cnt_q[i] + 1'b1;
               end
            end
         end
      end
   end

   assign fire_nxt = deb_fire & (af_ph_q | {2{~autofire}});
`else
   assign fire_nxt = deb_fire;
`endif

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         left1  <= 1'b0;
         right1 <= 1'b0;
         fire1  <= 1'b0;
         start1 <= 1'b0;
         left2  <= 1'b0;
         right2 <= 1'b0;
         fire2  <= 1'b0;
         start2 <= 1'b0;
      end else begin
         left1  <= rot ? deb_p1[BTN_DOWN] : deb_p1[BTN_LEFT];
         right1 <= rot ? deb_p1[BTN_UP]   : deb_p1[BTN_RIGHT];
         left2  <= rot ? deb_p2[BTN_DOWN] : deb_p2[BTN_LEFT];
         right2 <= rot ? deb_p2[BTN_UP]   : deb_p2[BTN_RIGHT];
         fire1  <= fire_nxt[0];
         fire2  <= fire_nxt[1];
         start1 <= deb_p1[BTN_START1] | deb_p2[BTN_START1];
         start2 <= deb_p1[BTN_START2] | deb_p2[BTN_START2];
      end
   end

   logic [1:0] coin_prev_q, coin_rise, nreq;
   coin_st_t   st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic       pend_q, pend_d;
   logic       expire;

   assign coin_rise = {deb_p2[BTN_COIN], deb_p1[BTN_COIN]} & ~coin_prev_q;
   assign nreq      = {1'b0, coin_rise[0]} + {1'b0, coin_rise[1]};
   assign expire    = tick && (cnt_q <= CW'(1));

   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      pend_d = pend_q;
      // One credit can queue behind the active pulse; extras are dropped.
      if (nreq != 2'd0 && st_q != IDLE) pend_d = 1'b1;
      case (st_q)
         IDLE: begin
            if (nreq != 2'd0) begin
               st_d   = PULSE;
               cnt_d  = CW'(COIN_MS);
               pend_d = (nreq == 2'd2);
            end
         end
         PULSE: begin
            if (expire) begin
               st_d  = GAP;
               cnt_d = CW'(GAP_MS);
            end else if (tick) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (expire) begin
               if (pend_q) begin
                  st_d   = PULSE;
                  cnt_d  = CW'(COIN_MS);
                  pend_d = (nreq != 2'd0);
               end else if (nreq != 2'd0) begin
                  st_d   = PULSE;
                  cnt_d  = CW'(COIN_MS);
                  pend_d = (nreq == 2'd2);
               end else begin
                  st_d   = IDLE;
                  cnt_d  = '0;
               end
            end else if (tick) begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            st_d   = IDLE;
            cnt_d  = '0;
            pend_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         coin_prev_q <= '0;
         st_q        <= IDLE;
         cnt_q       <= '0;
         pend_q      <= 1'b0;
      end else begin
         coin_prev_q <= {deb_p2[BTN_COIN], deb_p1[BTN_COIN]};
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
      end
   end

   assign coin      = (st_q == PULSE);
   assign coin_busy = (st_q != IDLE) | pend_q;

endmodule
